// File: rtl/chip8_display_scan.sv
// Raster scanner for the 64x32 CHIP-8 framebuffer: streams one pixel per valid/ready beat.
// Optional macro CHIP8_SCAN_SNAPSHOT_EN latches the framebuffer at frame start (tear-free).
module chip8_display_scan (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] display,
  input  logic          en,
  input  logic          pix_ready,
  output logic          pix_valid,
  output logic          pix_data,
  output logic [5:0]    pix_x,
  output logic [4:0]    pix_y,
  output logic          sof,
  output logic          eol,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic        hs;
  logic        last_beat;
  logic [2047:0] pix_src;

  assign hs        = (state_q == STREAM) && pix_ready;
  assign last_beat = (x_q == 6'd63) && (y_q == 5'd31);

`ifdef CHIP8_SCAN_SNAPSHOT_EN
  logic [2047:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (state_q == LOAD) snap_d = display;
  end

  always_ff @(posedge clk) begin
    if (reset) snap_q <= '0;
    else       snap_q <= snap_d;
  end

  assign pix_src = snap_q;
`else
  assign pix_src = display;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= 6'd0;
      y_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE:   if (en) state_d = LOAD;
      LOAD: begin
        state_d = STREAM;
        x_d     = 6'd0;
        y_d     = 5'd0;
      end
      STREAM: if (hs) begin
        // x wraps naturally at 63; y rolls over to 0 after the last row
        x_d = x_q + 6'd1;
        if (x_q == 6'd63) y_d = y_q + 5'd1;
        if (last_beat) state_d = DONE;
      end
      DONE:   state_d = en ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_valid  = (state_q == STREAM);
    pix_data   = pix_valid && pix_src[{y_q, x_q}];
    pix_x      = x_q;
    pix_y      = y_q;
    sof        = pix_valid && (x_q == 6'd0) && (y_q == 5'd0);
    eol        = pix_valid && (x_q == 6'd63);
    frame_done = (state_q == DONE);
  end

endmodule

// File: tb/tb_chip8_display_scan.sv
// Randomized bench for chip8_display_scan: a frame-level model (beat index, snapshot
// image) checked every cycle, plus directed scenarios with literal expectations.
module tb_chip8_display_scan;

  logic          clk = 1'b0;
  logic          reset;
  logic [2047:0] display;
  logic          en;
  logic          pix_ready;
  logic          pix_valid, pix_data, sof, eol, frame_done;
  logic [5:0]    pix_x;
  logic [4:0]    pix_y;

  int n_cmp = 0;
  int n_bad = 0;

  chip8_display_scan dut (
    .clk(clk), .reset(reset), .display(display), .en(en), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is 2048 beats numbered in raster order, bit index = beat index.
  bit            chk_en   = 1'b0;
  bit            m_active = 1'b0;
  bit            m_load   = 1'b0;
  bit            m_done   = 1'b0;
  int            m_idx    = 0;
  logic [2047:0] m_snap   = '0;

  always @(negedge clk) begin
    logic exp_bit;
    bit   nd;
    if (chk_en) begin
      chk("pix_valid", pix_valid, m_active);
      chk("frame_done", frame_done, m_done);
      if (m_active) begin
`ifdef CHIP8_SCAN_SNAPSHOT_EN
        exp_bit = m_snap[m_idx];
`else
        exp_bit = display[m_idx];
`endif
        chk("pix_x", pix_x, m_idx % 64);
        chk("pix_y", pix_y, m_idx / 64);
        chk("pix_data", pix_data, exp_bit);
        chk("sof", sof, m_idx == 0);
        chk("eol", eol, (m_idx % 64) == 63);
      end else begin
        chk("idle_sof", sof, 0);
        chk("idle_eol", eol, 0);
        chk("idle_data", pix_data, 0);
      end
    end
    // Inputs are stable from here to the next rising edge, so advance the model now.
    if (reset) begin
      m_active = 0; m_load = 0; m_done = 0; m_idx = 0;
      chk_en = 1'b1;
    end else begin
      nd = 0;
      if (m_active && pix_ready) begin
        if (m_idx == 2047) begin m_active = 0; nd = 1; end
        else m_idx++;
      end else if (m_load) begin
        m_load = 0; m_active = 1; m_idx = 0; m_snap = display;
      end else if (!m_active && en) begin
        m_load = 1;
      end
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_beat(input int bx, input int by, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (pix_valid && pix_x == bx && pix_y == by) return;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_done(input int budget, input string name, input int init, output int lit);
    lit = init;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (frame_done) return;
      if (pix_valid && pix_ready) lit += int'(pix_data);
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  // Request a frame from IDLE and pin the two-cycle start latency.
  task automatic start_frame(input string name, input bit hold);
    en = 1'b1;
    tick();
    if (!hold) en = 1'b0;
    @(negedge clk);
    chk({name, "_load_valid"}, pix_valid, 0);
    @(negedge clk);
    chk({name, "_first_valid"}, pix_valid, 1);
    chk({name, "_first_sof"}, sof, 1);
    chk({name, "_first_x"}, pix_x, 0);
    chk({name, "_first_y"}, pix_y, 0);
  endtask

  task automatic randomize_display();
    for (int i = 0; i < 64; i++) display[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int lit1, lit2, pulses;
    reset = 1'b1; en = 1'b0; pix_ready = 1'b1; display = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_sof", sof, 0);

    // Corner pixels lit, full-speed sink
    tick();
    display[0] = 1'b1; display[2047] = 1'b1;
    start_frame("t030", 0);
    chk("t030_beat0_data", pix_data, 1);
    wait_beat(63, 31, 2100, "t030_last");
    chk("t030_last_data", pix_data, 1);
    chk("t030_last_eol", eol, 1);
    @(negedge clk);
    chk("t030_done", frame_done, 1);
    chk("t030_done_valid", pix_valid, 0);
    @(negedge clk);
    chk("t030_done_once", frame_done, 0);

    // Backpressure at (10,0), then random ready for the rest of the frame
    tick();
    randomize_display();
    start_frame("t031", 0);
    wait_beat(9, 0, 20, "t031_b9");
    tick();
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t031_hold_valid", pix_valid, 1);
      chk("t031_hold_x", pix_x, 10);
    end
    tick();
    pix_ready = 1'b1;
    @(negedge clk);
    chk("t031_still_x", pix_x, 10);
    @(negedge clk);
    chk("t031_resume_x", pix_x, 11);
    chk("t031_resume_y", pix_y, 0);
    for (int n = 0; n < 6000; n++) begin
      tick();
      pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (frame_done) break;
      if (n == 5999) chk("t031_timeout", 1, 0);
    end
    tick();
    pix_ready = 1'b1;

    // Live update of display[100] = (36,1) while the frame is running
    display = '0;
    start_frame("t032", 0);
    wait_beat(50, 0, 100, "t032_b50");
    tick();
    display[100] = 1'b1;
    wait_beat(36, 1, 100, "t032_b100");
`ifdef CHIP8_SCAN_SNAPSHOT_EN
    chk("t032_pix100", pix_data, 0);
`else
    chk("t032_pix100", pix_data, 1);
`endif
    wait_done(2100, "t032_done", 0, lit1);

    // Reset mid-frame
    tick();
    randomize_display();
    start_frame("t033", 0);
    wait_beat(52, 7, 600, "t033_b500");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t033_valid", pix_valid, 0);
    chk("t033_x", pix_x, 0);
    chk("t033_y", pix_y, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pulses += int'(frame_done);
    end
    chk("t033_no_done", pulses, 0);
    tick();
    start_frame("t033_restart", 0);
    wait_done(2100, "t033_done", int'(pix_data), lit1);

    // en dropped mid-frame: frame completes, then IDLE
    tick();
    start_frame("t034", 1);
    wait_beat(40, 15, 1100, "t034_b1000");
    tick();
    en = 1'b0;
    wait_done(1100, "t034_done", 0, lit1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t034_idle_valid", pix_valid, 0);
    end

    // en held: back-to-back identical frames
    tick();
    randomize_display();
    en = 1'b1;
    wait_done(2200, "t035_f1", 0, lit1);
    @(negedge clk);
    chk("t035_load_valid", pix_valid, 0);
    @(negedge clk);
    chk("t035_sof", sof, 1);
    wait_done(2100, "t035_f2", int'(pix_data), lit2);
    chk("t035_same_frames", lit2, lit1);
    chk("t035_lit_count", lit1, $countones(display));
    tick();
    en = 1'b0;
    wait_done(2200, "t035_f3", 0, lit2);
    chk("t035_f3_lit", lit2, lit1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
